// File: rtl/int_alu_arbiter.sv
// Round-robin arbiter sharing one combinational integer ALU between two requesters.
// Results are captured with tag and source ID into a small FIFO drained by valid/ready.
module int_alu_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = 5,
    parameter int CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              req0_valid_i,
    input  logic              req1_valid_i,
    output logic              req0_ready_o,
    output logic              req1_ready_o,
    input  logic [31:0]       req0_instr_i,
    input  logic [31:0]       req1_instr_i,
    input  logic [63:0]       req0_data_a_i,
    input  logic [63:0]       req1_data_a_i,
    input  logic [63:0]       req0_data_b_i,
    input  logic [63:0]       req1_data_b_i,
    input  logic [TAG_W-1:0]  req0_tag_i,
    input  logic [TAG_W-1:0]  req1_tag_i,
    output logic [31:0]       alu_instr_o,
    output logic [63:0]       alu_data_a_o,
    output logic [63:0]       alu_data_b_o,
    input  logic [63:0]       alu_data_out_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [63:0]       res_data_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              res_src_o,
    output logic [CNT_W-1:0]  grant_cnt0_o,
    output logic [CNT_W-1:0]  grant_cnt1_o
);

    localparam int              PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    entry_t             wr_entry;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;
    logic               gnt0, gnt1, enq, deq, space;

    assign res_valid_o = (count_q != '0);
    assign deq         = res_valid_o && res_ready_i;
    // A dequeue in the same cycle frees its slot, so a full FIFO can still accept.
    assign space       = (count_q < FULL) || deq;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rsn_i && space) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    always_comb begin
        alu_instr_o  = '0;
        alu_data_a_o = '0;
        alu_data_b_o = '0;
        wr_entry     = '0;
        if (gnt0) begin
            alu_instr_o  = req0_instr_i;
            alu_data_a_o = req0_data_a_i;
            alu_data_b_o = req0_data_b_i;
            wr_entry.tag = req0_tag_i;
        end else if (gnt1) begin
            alu_instr_o  = req1_instr_i;
            alu_data_a_o = req1_data_a_i;
            alu_data_b_o = req1_data_b_i;
            wr_entry.tag = req1_tag_i;
        end
        wr_entry.data = alu_data_out_i;
        wr_entry.src  = gnt1;
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign enq          = gnt0 || gnt1;

    always_comb begin
        wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        last_d = enq ? gnt1 : last_q;
        cnt0_d = (gnt0 && (cnt0_q != '1)) ? cnt0_q + 1'b1 : cnt0_q;
        cnt1_d = (gnt1 && (cnt1_q != '1)) ? cnt1_q + 1'b1 : cnt1_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b1;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // NOTE: storage is not reset; count_q alone decides whether an entry is visible.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign res_data_o   = head.data;
    assign res_tag_o    = head.tag;
    assign res_src_o    = head.src;
    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_int_alu_arbiter.sv
// Bench for int_alu_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of arbitration, result ordering and grant counting.
module tb_int_alu_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rsn;
    logic        v0, v1, res_ready;
    logic [31:0] instr0, instr1;
    logic [63:0] a0, a1, b0, b1;
    logic [4:0]  tag0, tag1;
    logic        ready0, ready1;
    logic [31:0] alu_instr;
    logic [63:0] alu_a, alu_b, alu_out;
    logic        res_valid, res_src;
    logic [63:0] res_data;
    logic [4:0]  res_tag;
    logic [15:0] gcnt0, gcnt1;

    // Second instance with narrow counters for saturation.
    logic        sat_v1;
    logic        sat_r0, sat_r1, sat_rv, sat_rs;
    logic [31:0] sat_ai;
    logic [63:0] sat_aa, sat_ab, sat_rd;
    logic [4:0]  sat_rt;
    logic [1:0]  sat_c0, sat_c1;

    always #5 clk = ~clk;

    // Tiny ALU: ADDI, ADD, otherwise XOR.
    function automatic logic [63:0] alu_fn(input logic [31:0] i, input logic [63:0] a, input logic [63:0] b);
        if (i[6:0] == 7'b0010011 && i[14:12] == 3'b000) return a + {{52{i[31]}}, i[31:20]};
        if (i[6:0] == 7'b0110011) return a + b;
        return a ^ b;
    endfunction

    assign alu_out = alu_fn(alu_instr, alu_a, alu_b);

    int_alu_arbiter #(.FIFO_DEPTH(DEPTH), .TAG_W(5), .CNT_W(16)) u_dut (
        .clk_i(clk), .rsn_i(rsn),
        .req0_valid_i(v0), .req1_valid_i(v1),
        .req0_ready_o(ready0), .req1_ready_o(ready1),
        .req0_instr_i(instr0), .req1_instr_i(instr1),
        .req0_data_a_i(a0), .req1_data_a_i(a1),
        .req0_data_b_i(b0), .req1_data_b_i(b1),
        .req0_tag_i(tag0), .req1_tag_i(tag1),
        .alu_instr_o(alu_instr), .alu_data_a_o(alu_a), .alu_data_b_o(alu_b),
        .alu_data_out_i(alu_out),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_tag_o(res_tag), .res_src_o(res_src),
        .grant_cnt0_o(gcnt0), .grant_cnt1_o(gcnt1)
    );

    int_alu_arbiter #(.FIFO_DEPTH(2), .TAG_W(5), .CNT_W(2)) u_sat (
        .clk_i(clk), .rsn_i(rsn),
        .req0_valid_i(1'b0), .req1_valid_i(sat_v1),
        .req0_ready_o(sat_r0), .req1_ready_o(sat_r1),
        .req0_instr_i(32'h0), .req1_instr_i(32'h0),
        .req0_data_a_i(64'h0), .req1_data_a_i(64'h0),
        .req0_data_b_i(64'h0), .req1_data_b_i(64'h0),
        .req0_tag_i(5'h0), .req1_tag_i(5'h0),
        .alu_instr_o(sat_ai), .alu_data_a_o(sat_aa), .alu_data_b_o(sat_ab),
        .alu_data_out_i(64'h0),
        .res_valid_o(sat_rv), .res_ready_i(1'b1),
        .res_data_o(sat_rd), .res_tag_o(sat_rt), .res_src_o(sat_rs),
        .grant_cnt0_o(sat_c0), .grant_cnt1_o(sat_c1)
    );

    // Reference model state.
    typedef struct {
        logic [63:0] d;
        logic [4:0]  t;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   last_g;
    int   cnt0, cnt1;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_g = 1;
        cnt0   = 0;
        cnt1   = 0;
    endtask

    // One clock cycle starting at a negedge with inputs already applied.
    task automatic step(output int g);
        logic [31:0] ei;
        logic [63:0] ea, eb;
        bit          space;
        exp_t        e;
        #1;
        space = (q.size() < DEPTH) || (q.size() > 0 && res_ready);
        g = -1;
        if (space) begin
            if (v0 && v1) g = (last_g == 1) ? 0 : 1;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        ei = (g == 0) ? instr0 : (g == 1) ? instr1 : 32'h0;
        ea = (g == 0) ? a0     : (g == 1) ? a1     : 64'h0;
        eb = (g == 0) ? b0     : (g == 1) ? b1     : 64'h0;
        check("ready0", ready0, 64'(g == 0));
        check("ready1", ready1, 64'(g == 1));
        check("alu_instr", alu_instr, ei);
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("res_valid", res_valid, 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("res_data", res_data, q[0].d);
            check("res_tag", res_tag, q[0].t);
            check("res_src", res_src, q[0].s);
        end
        check("cnt0", gcnt0, cnt0);
        check("cnt1", gcnt1, cnt1);
        @(posedge clk);
        if (q.size() != 0 && res_ready) void'(q.pop_front());
        if (g >= 0) begin
            e.d = alu_fn(ei, ea, eb);
            e.t = (g == 0) ? tag0 : tag1;
            e.s = (g == 1);
            q.push_back(e);
            last_g = g;
            if (g == 0 && cnt0 < 65535) cnt0++;
            if (g == 1 && cnt1 < 65535) cnt1++;
        end
        @(negedge clk);
    endtask

    task automatic rand_req(input int n);
        logic [31:0] r, r2;
        int          sel;
        logic [31:0] ins;
        r   = $urandom;
        r2  = $urandom;
        sel = $urandom_range(0, 2);
        if (sel == 0)      ins = {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
        else if (sel == 1) ins = {7'b0, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
        else               ins = r;
        if (n == 0) begin
            instr0 = ins; a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; tag0 = r2[4:0];
        end else begin
            instr1 = ins; a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; tag1 = r2[4:0];
        end
    endtask

    task automatic do_reset();
        rsn = 1'b0;
        #1;
        check("rst_res_valid", res_valid, 0);
        @(negedge clk);
        rsn = 1'b1;
        model_reset();
    endtask

    initial begin
        int g, g_prev;
        rsn = 1'b0; v0 = 1'b1; v1 = 1'b1; res_ready = 1'b0; sat_v1 = 1'b0;
        instr0 = 32'h0000_0033; instr1 = 32'h0000_0033;
        a0 = 64'h11; a1 = 64'h22; b0 = 64'h33; b1 = 64'h44; tag0 = 5'd1; tag1 = 5'd2;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        // Requests held valid during reset must see no grant and a quiet ALU bus.
        check("rst_ready0", ready0, 0);
        check("rst_ready1", ready1, 0);
        check("rst_alu_instr", alu_instr, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_cnt0", gcnt0, 0);
        check("rst_cnt1", gcnt1, 0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        rsn = 1'b1;

        // ADDI x1, x0, 5 with A = 10, tag 3.
        instr0 = 32'h0050_0093; a0 = 64'd10; b0 = 64'd0; tag0 = 5'd3; v0 = 1'b1; res_ready = 1'b1;
        step(g);
        v0 = 1'b0;
        #1;
        check("t1_res_valid", res_valid, 1);
        check("t1_res_data", res_data, 64'd15);
        check("t1_res_tag", res_tag, 3);
        check("t1_res_src", res_src, 0);
        check("t1_cnt0", gcnt0, 1);
        step(g);

        // Both valid after reset: grants alternate starting with req0.
        do_reset();
        rand_req(0); rand_req(1);
        v0 = 1'b1; v1 = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(g);
            check("alt_src", res_src, i % 2);
            if (g >= 0) rand_req(g);
        end

        // Drain, then fill with the consumer stalled.
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) step(g);
        res_ready = 1'b0; v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(g);
            if (g >= 0) rand_req(g);
        end
        #1;
        check("full_ready0", ready0, 0);
        check("full_ready1", ready1, 0);
        res_ready = 1'b1;
        #1;
        check("full_release_grant", ready0 | ready1, 1);
        step(g);
        v0 = 1'b0; v1 = 1'b0;
        repeat (3) step(g);

        // Steady enqueue+dequeue at count 1 with incrementing tags.
        v0 = 1'b1; tag0 = 5'd0; rand_req(0); tag0 = 5'd0;
        step(g);
        for (int i = 0; i < 10; i++) begin
            tag0 = 5'(i + 1);
            step(g);
            check("wrap_tag", res_tag, i + 1);
        end
        v0 = 1'b0;
        repeat (2) step(g);

        // Reset with two queued results flushes them; first tie goes to req0.
        res_ready = 1'b0; v0 = 1'b1; v1 = 1'b1;
        step(g); if (g >= 0) rand_req(g);
        step(g); if (g >= 0) rand_req(g);
        #2;
        rsn = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_ready0", ready0, 0);
        check("mid_rst_alu_a", alu_a, 0);
        @(negedge clk);
        #2;
        rsn = 1'b1;
        model_reset();
        check("post_rst_res_valid", res_valid, 0);
        step(g);
        check("post_rst_src", res_src, 0);
        v0 = 1'b0; v1 = 1'b0; res_ready = 1'b1;
        repeat (2) step(g);

        // Randomized traffic; unaccepted requests hold their fields.
        g_prev = -1;
        for (int i = 0; i < 400; i++) begin
            if (!(v0 && g_prev != 0)) begin v0 = ($urandom_range(0, 3) != 0); rand_req(0); end
            if (!(v1 && g_prev != 1)) begin v1 = ($urandom_range(0, 3) != 0); rand_req(1); end
            res_ready = ($urandom_range(0, 2) != 0);
            step(g);
            g_prev = g;
        end
        v0 = 1'b0; v1 = 1'b0; res_ready = 1'b1;
        repeat (3) step(g);

        // Narrow counter saturates at all-ones.
        sat_v1 = 1'b1;
        repeat (2) @(negedge clk);
        check("sat_cnt_2", sat_c1, 2);
        repeat (3) @(negedge clk);
        sat_v1 = 1'b0;
        #1;
        check("sat_cnt_5", sat_c1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
